// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the neuron datapath blocks.
//   - Default fixed-point format (DATA_WIDTH / FRAC_BITS).
//   - neuron_state_t: evaluation FSM states of the MAC stage.
//   - sat_limit(): most positive / most negative value of a signed width,
//     used to build saturation constants.
// -----------------------------------------------------------------------------
package nn_pkg;

    localparam int NN_DATA_WIDTH = 16;
    localparam int NN_FRAC_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } neuron_state_t;

    // Returns the saturation bound of a signed two's complement number of
    // 'width' bits: the maximum when 'upper' is set, otherwise the minimum.
    // Result is sign-extended to 64 bits; callers slice the low bits.
    function automatic logic signed [63:0] sat_limit(input int width, input logic upper);
        if (upper) begin
            return (64'sd1 <<< (width - 1)) - 64'sd1;
        end
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// -----------------------------------------------------------------------------
// fxp_round_sat
// Combinational rescale of a wide signed fixed-point value to a narrow one:
// arithmetic right shift by FRAC_BITS (truncation toward -inf) followed by
// saturation to the signed OUT_WIDTH range.
// Ports:
//   i_value  in  IN_WIDTH   signed wide value (FRAC_BITS extra fraction bits)
//   o_value  out OUT_WIDTH  signed rescaled, saturated value
// Requires IN_WIDTH > OUT_WIDTH.
// -----------------------------------------------------------------------------
module fxp_round_sat #(
    parameter int IN_WIDTH  = 34,
    parameter int OUT_WIDTH = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic signed [IN_WIDTH-1:0]  i_value,
    output logic signed [OUT_WIDTH-1:0] o_value
);
    import nn_pkg::*;

    localparam logic signed [63:0] MAX_L = sat_limit(OUT_WIDTH, 1'b1);
    localparam logic signed [63:0] MIN_L = sat_limit(OUT_WIDTH, 1'b0);

    logic signed [IN_WIDTH-1:0]    w_shifted;
    // Bits from the output sign bit upward; they must all agree for the
    // shifted value to be representable in OUT_WIDTH bits.
    logic [IN_WIDTH-OUT_WIDTH:0]   w_top;
    logic                          w_ovf;

    assign w_shifted = i_value >>> FRAC_BITS;
    assign w_top     = w_shifted[IN_WIDTH-1:OUT_WIDTH-1];
    assign w_ovf     = !((&w_top) || !(|w_top));

    always_comb begin
        o_value = w_shifted[OUT_WIDTH-1:0];
        if (w_ovf) begin
            o_value = w_top[IN_WIDTH-OUT_WIDTH] ? MIN_L[OUT_WIDTH-1:0]
                                                : MAX_L[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac
// Single-neuron multiply-accumulate stage. Accepts NUM_INPUTS signed
// activations, reads one weight per activation from the weight memory
// (1-cycle read latency), accumulates the full-precision products, adds the
// bias, rescales and emits one saturated result per evaluation.
// Ports:
//   i_clk     in  1           clock
//   i_rst     in  1           synchronous active-high reset
//   i_data    in  DATA_WIDTH  activation
//   i_valid   in  1           i_data valid
//   o_ready   out 1           activation accepted this cycle if i_valid
//   i_bias    in  DATA_WIDTH  bias, sampled with the first activation
//   o_ren     out 1           weight memory read enable (= accept)
//   o_raddr   out ADDR_WIDTH  weight memory read address (input index)
//   i_weight  in  DATA_WIDTH  weight from memory
//   i_wvalid  in  1           i_weight valid
//   o_data    out DATA_WIDTH  pre-activation result (held between pulses)
//   o_valid   out 1           o_data valid, one-cycle pulse
// -----------------------------------------------------------------------------
module neuron_mac #(
    parameter int DATA_WIDTH = nn_pkg::NN_DATA_WIDTH,
    parameter int FRAC_BITS  = nn_pkg::NN_FRAC_BITS,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_INPUTS = 784
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_bias,
    output logic                  o_ren,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    input  logic [DATA_WIDTH-1:0] i_weight,
    input  logic                  i_wvalid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);
    import nn_pkg::*;

    localparam int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(NUM_INPUTS) + 1;
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    // One guard bit so acc + shifted bias cannot wrap.
    localparam int SUM_WIDTH  = ACC_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_INPUTS - 1);

    neuron_state_t                 r_state;
    logic                          r_ready;
    logic [ADDR_WIDTH-1:0]         r_cnt;
    logic                          w_accept;
    logic                          w_last;

    logic signed [DATA_WIDTH-1:0]  r_act_p0;
    logic signed [DATA_WIDTH-1:0]  r_bias;
    logic                          r_vld_p0;
    logic                          r_vld_p1;
    logic signed [PROD_WIDTH-1:0]  w_act_ext;
    logic signed [PROD_WIDTH-1:0]  w_wgt_ext;
    logic signed [PROD_WIDTH-1:0]  w_prod;
    logic signed [PROD_WIDTH-1:0]  r_prod_p1;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic signed [ACC_WIDTH-1:0]   w_prod_acc;
    logic signed [SUM_WIDTH-1:0]   w_acc_ext;
    logic signed [SUM_WIDTH-1:0]   w_bias_ext;
    logic signed [SUM_WIDTH-1:0]   w_sum;
    logic signed [DATA_WIDTH-1:0]  w_result;

    assign w_accept = i_valid && r_ready;
    assign w_last   = (r_cnt == LAST_IDX);

    assign o_ren    = w_accept;
    assign o_ready  = r_ready;
    assign o_raddr  = r_cnt;

    // Operands widened to the product width so the signed multiply is exact.
    assign w_act_ext  = {{DATA_WIDTH{r_act_p0[DATA_WIDTH-1]}}, r_act_p0};
    assign w_wgt_ext  = {{DATA_WIDTH{i_weight[DATA_WIDTH-1]}}, i_weight};
    assign w_prod     = w_act_ext * w_wgt_ext;
    assign w_prod_acc = {{(ACC_WIDTH-PROD_WIDTH){r_prod_p1[PROD_WIDTH-1]}}, r_prod_p1};

    // Bias is in the activation format; shift it up to the product format.
    assign w_acc_ext  = {r_acc[ACC_WIDTH-1], r_acc};
    assign w_bias_ext = {{(SUM_WIDTH-DATA_WIDTH){r_bias[DATA_WIDTH-1]}}, r_bias};
    assign w_sum      = w_acc_ext + (w_bias_ext <<< FRAC_BITS);

    fxp_round_sat #(
        .IN_WIDTH  (SUM_WIDTH),
        .OUT_WIDTH (DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
        .i_value (w_sum),
        .o_value (w_result)
    );

    // Data registers: no reset needed, qualified by the valid pipeline.
    always_ff @(posedge i_clk) begin
        // Stage 0: activation held until its weight returns.
        if (w_accept) begin
            r_act_p0 <= i_data;
        end
        if (w_accept && (r_state == IDLE)) begin
            r_bias <= i_bias;
        end
        // Stage 1: product of activation and returned weight.
        if (r_vld_p0 && i_wvalid) begin
            r_prod_p1 <= w_prod;
        end
    end

    // Valid pipeline and accumulator.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_acc    <= '0;
        end else begin
            r_vld_p0 <= w_accept;
            // A missing read-valid drops the product rather than using stale data.
            r_vld_p1 <= r_vld_p0 && i_wvalid;
            // Stage 2: accumulate.
            if (r_state == OUTPUT) begin
                r_acc <= '0;
            end else if (r_vld_p1) begin
                r_acc <= r_acc + w_prod_acc;
            end
        end
    end

    // Evaluation control with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_cnt   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= 1'b0;
            if (w_accept) begin
                r_cnt <= w_last ? '0 : r_cnt + ADDR_WIDTH'(1);
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_state <= DRAIN;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (w_accept && w_last) begin
                        r_state <= DRAIN;
                        r_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    // The last product sits in stage 1 once stage 0 has emptied;
                    // it is accumulated on this same edge.
                    if (!r_vld_p0) begin
                        r_state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    o_data  <= w_result;
                    o_valid <= 1'b1;
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
